layer_sequencer: RTL
====================

# layer_sequencer

Sequencing controller for a time-multiplexed fully-connected layer. A single shared FP32 multiply-accumulate/bias/activation datapath replaces the OUT_SIZE×IN_SIZE parallel array. On `start` the block walks every output neuron j and every input i. It issues one operand-pair request per (j, i) over a valid/ready handshake, waits for the datapath's finished neuron result, then pulses a write strobe into the output register file. It sits between the network-level control FSM and the shared neuron datapath. It carries only indices and control; no float arithmetic.

## Interface
Parameters:
- `IN_SIZE`, 1, inputs per neuron (≥1)
- `OUT_SIZE`, 1, neurons in the layer (≥1)
- Derived: `IW` = max(1, $clog2(IN_SIZE)), `OW` = max(1, $clog2(OUT_SIZE))

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a layer pass; sampled only in IDLE
- `busy`  out  1  high in ISSUE, WAIT, FINISH
- `done`  out  1  one-cycle pulse at end of pass
- `err`  out  1  sticky protocol error; cleared on accepted `start`
- `mac_valid`  out  1  operand request valid
- `mac_ready`  in  1  datapath accepts request
- `mac_first`  out  1  request is term i=0 (datapath clears accumulator)
- `mac_last`  out  1  request is term i=IN_SIZE-1 (datapath adds bias, applies activation)
- `neuron_idx`  out  OW  current j (weight row, bias index)
- `in_idx`  out  IW  current i (input element, weight column)
- `res_valid`  in  1  datapath's finished neuron result is present
- `wr_en`  out  1  write datapath result to output slot `wr_idx`
- `wr_idx`  out  OW  equals `neuron_idx`
- `cycles`  out  32  busy-cycle count (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: when `start`=1, set j=0, i=0, clear `err` and `cycles`, and go to ISSUE.
- ISSUE:
  - `mac_valid`=1, `mac_first`=(i==0), `mac_last`=(i==IN_SIZE-1).
  - On `mac_ready`=1 with i<IN_SIZE-1: i←i+1.
  - On `mac_ready`=1 with i==IN_SIZE-1: go to WAIT.
  - `mac_ready`=0: hold all outputs stable, with no index change.
- WAIT:
  - `mac_valid`=0.
  - `wr_en` = `res_valid`, combinational in the same cycle.
  - On `res_valid`=1 with j<OUT_SIZE-1: j←j+1, i←0, go to ISSUE.
  - On `res_valid`=1 with j==OUT_SIZE-1: go to FINISH.
- FINISH: `done`=1 for exactly this cycle, then go to IDLE; indices return to 0.
- `res_valid`=1 in any state other than WAIT is a protocol error: set `err`, no `wr_en`, state unaffected.
- `start` outside IDLE is ignored; it does not restart the pass and does not set `err`.
- `wr_en` and `mac_valid` are never high in the same cycle.
- Indices never exceed IN_SIZE-1 / OUT_SIZE-1. No wrap-around beyond the last neuron; the pass terminates.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `mac_valid`, `mac_first`, `mac_last`, `wr_en` = 0.
  - `neuron_idx`, `in_idx`, `wr_idx` = 0; `cycles` = 0.
- Reset mid-pass: IDLE on the next edge. No `done`, no further `wr_en`, and an in-flight request is abandoned.
- `start` accepted at edge N → first request in cycle N+1.
- Pass length with `mac_ready`=1 and `res_valid` high on WAIT entry: `done` in cycle N + OUT_SIZE·(IN_SIZE+1) + 1.
- Each `mac_ready` low cycle adds one cycle; each cycle WAIT spends without `res_valid` adds one cycle.
- IN_SIZE=1: every request has `mac_first`=`mac_last`=1.

## Configuration
- Macro `LAYER_SEQ_PERF_EN`.
- Defined:
  - `cycles` counts every clock with `busy`=1, cleared on an accepted `start`, and holds after `done` until the next `start`.
  - The counter saturates at 2^32-1.
- Undefined: `cycles` is tied to 0 and no counter register is built.

## Test plan
- Reset, then IN_SIZE=2, OUT_SIZE=1, `mac_ready`=1, `res_valid`=1 constantly after WAIT entry, `start` at cycle 0:
  - requests (0,0) first=1 at cycle 1 and (0,1) last=1 at cycle 2.
  - `wr_en` with `wr_idx`=0 at cycle 3; `done` at cycle 4.
  - `cycles`=4 with `LAYER_SEQ_PERF_EN` defined.
- IN_SIZE=3, OUT_SIZE=2, `mac_ready` low on every other cycle:
  - request sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), each held stable while stalled.
  - `wr_en` twice, `wr_idx` 0 then 1.
- `res_valid` delayed 5 cycles in WAIT for neuron 0: no `wr_en` and no index change during the delay; `done` is 5 cycles later than baseline.
- `res_valid` pulsed during ISSUE: `err`=1 and stays 1, no `wr_en`, and the pass completes normally. The next `start` clears `err`.
- `rst` asserted in WAIT of neuron 1 of 3: all outputs 0 next cycle, and no `done`. A new `start` restarts at (0,0).
- `start` re-asserted while `busy`: ignored, with request sequence and `done` timing identical to the undisturbed pass.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// Datapath-facing bundle of the layer sequencer: operand requests out,
// finished-neuron results in, and the output register-file write strobe.
interface layer_sequencer_if #(
    parameter int IW = 1,
    parameter int OW = 1
);
    // Request handshake: a request transfers on a cycle where mac_valid and
    // mac_ready are both high. While mac_valid is high and mac_ready is low,
    // mac_first, mac_last, neuron_idx and in_idx hold their values. res_valid
    // has no back-pressure; it is consumed in the cycle it is seen in WAIT.
    logic          mac_valid;
    logic          mac_ready;
    logic          mac_first;
    logic          mac_last;
    logic [OW-1:0] neuron_idx;
    logic [IW-1:0] in_idx;
    logic          res_valid;
    logic          wr_en;
    logic [OW-1:0] wr_idx;

    modport master (
        output mac_valid, mac_first, mac_last, neuron_idx, in_idx, wr_en, wr_idx,
        input  mac_ready, res_valid
    );

    modport slave (
        input  mac_valid, mac_first, mac_last, neuron_idx, in_idx, wr_en, wr_idx,
        output mac_ready, res_valid
    );
endinterface

// File: rtl/layer_sequencer.sv
// Index/handshake sequencer for a time-multiplexed fully-connected layer.
// Define LAYER_SEQ_PERF_EN to build the saturating busy-cycle counter.
module layer_sequencer #(
    parameter int IN_SIZE  = 1,
    parameter int OUT_SIZE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycles,
    output logic [1:0]        dbg_state,
    layer_sequencer_if.master dp
);
    localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(IN_SIZE - 1);
    localparam logic [OW-1:0] LAST_J = OW'(OUT_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [OW-1:0] r_j, w_j_nxt;
    logic [IW-1:0] r_i, w_i_nxt;
    logic          r_err, w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_i     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_i     <= w_i_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_i_nxt     = r_i;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_j_nxt     = '0;
                    w_i_nxt     = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dp.mac_ready) begin
                    if (r_i == LAST_I) w_state_nxt = S_WAIT;
                    else               w_i_nxt     = r_i + 1'b1;
                end
            end
            S_WAIT: begin
                if (dp.res_valid) begin
                    if (r_j == LAST_J) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_j_nxt     = r_j + 1'b1;
                        w_i_nxt     = '0;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                w_j_nxt     = '0;
                w_i_nxt     = '0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A result outside WAIT has no slot to go to; flag it and leave the walk alone.
        if (dp.res_valid && (r_state != S_WAIT)) w_err_nxt = 1'b1;
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FINISH);
    assign err           = r_err;
    assign dbg_state     = r_state;
    assign dp.mac_valid  = (r_state == S_ISSUE);
    assign dp.mac_first  = (r_state == S_ISSUE) && (r_i == '0);
    assign dp.mac_last   = (r_state == S_ISSUE) && (r_i == LAST_I);
    assign dp.neuron_idx = r_j;
    assign dp.in_idx     = r_i;
    assign dp.wr_en      = (r_state == S_WAIT) && dp.res_valid;
    assign dp.wr_idx     = r_j;

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) r_cycles <= '0;
        end else if (r_cycles != 32'hFFFF_FFFF) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign cycles = r_cycles;
`else
    assign cycles = 32'd0;
`endif
endmodule
